aq_djpeg_idct_out: RTL and testbench

Output stage that drains the IDCT transpose buffer. It reads one completed 8x8 block as 32 coefficient pairs: it issues addresses, captures the 1-cycle-latency RAM data and corrects the A/B lane steering. Each sample is then descaled with rounding, level-shifted by +128 and clamped to 8 bits. Pixel pairs go out through a small FIFO with valid/ready backpressure towards the colour-conversion stage.

---
 rtl/aq_djpeg_idct_out_if.sv | 28 ++
 rtl/aq_djpeg_idct_out.sv | 123 ++++++++++++
 tb/tb_aq_djpeg_idct_out.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/aq_djpeg_idct_out_if.sv
// Bus between the IDCT transpose buffer, this output stage and colour conversion.
// Read side: 1-cycle-latency address/data pairs. Write side: valid/ready pixel pairs.
interface aq_djpeg_idct_out_if;
  logic               DataInit;
  logic               DataInEnable;
  logic               DataInRead;
  logic [4:0]         DataInAddress;
  logic signed [15:0] DataInA;
  logic signed [15:0] DataInB;
  logic               DataOutEnable;
  logic               DataOutReady;
  logic [4:0]         DataOutAddress;
  logic [7:0]         DataOutA;
  logic [7:0]         DataOutB;
  logic               DataOutLast;

  modport slave (
    input  DataInit, DataInEnable, DataInA, DataInB, DataOutReady,
    output DataInRead, DataInAddress, DataOutEnable, DataOutAddress,
           DataOutA, DataOutB, DataOutLast
  );

  modport master (
    output DataInit, DataInEnable, DataInA, DataInB, DataOutReady,
    input  DataInRead, DataInAddress, DataOutEnable, DataOutAddress,
           DataOutA, DataOutB, DataOutLast
  );
endinterface

// File: rtl/aq_djpeg_idct_out.sv
// Drains one 8x8 block from the transpose buffer as 32 pairs: descale, +128, clamp to 8 bits.
// Pixel is written to the output FIFO 2 cycles after its address is issued; reads stall on FIFO credit.
module aq_djpeg_idct_out #(
  parameter int SHIFT = 3,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  aq_djpeg_idct_out_if.slave    io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [17:0] RND =
    (SHIFT > 0) ? (18'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 18'sd0;

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
  } pair_t;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, last_addr_q;
  logic [1:0]      inflight_q;
  logic            issue_v_q;
  logic [4:0]      issue_addr_q;
  pair_t           mem_q [DEPTH];
  pair_t           hold_q, head, wr_pair;
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count_q;
  logic            clr, credit, issue, push, pop, swap;
  logic signed [15:0] lane_a, lane_b;

  function automatic logic [7:0] to_pixel(input logic signed [15:0] x);
    logic signed [17:0] s;
    logic signed [17:0] y;
    s = $signed({{2{x[15]}}, x}) + RND;
    y = (s >>> SHIFT) + 18'sd128;
    if (y < 0)
      return 8'd0;
    else if (y > 18'sd255)
      return 8'd255;
    else
      return y[7:0];
  endfunction

  assign clr    = rst | io.DataInit;
  assign credit = (int'(count_q) + int'(inflight_q)) < DEPTH;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: if (io.DataInEnable) state_d = RUN;
      RUN: begin
        if (credit) begin
          issue = 1'b1;
          // Leaving RUN only at a block boundary keeps the buffer bank aligned.
          if (cnt_q == 5'd31 && !io.DataInEnable) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.DataInRead    = issue;
  assign io.DataInAddress = issue ? cnt_q : last_addr_q;

  // The buffer steers lanes by its live address bit 4, which may differ from the captured one.
  assign swap    = issue_addr_q[4] != io.DataInAddress[4];
  assign lane_a  = swap ? io.DataInB : io.DataInA;
  assign lane_b  = swap ? io.DataInA : io.DataInB;
  assign wr_pair = '{addr: issue_addr_q, a: to_pixel(lane_a), b: to_pixel(lane_b),
                     last: issue_addr_q == 5'd31};

  assign push = issue_v_q;
  assign pop  = (count_q != '0) && io.DataOutReady;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_addr_q  <= '0;
      inflight_q   <= '0;
      issue_v_q    <= 1'b0;
      issue_addr_q <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      issue_v_q    <= issue;
      issue_addr_q <= io.DataInAddress;
      inflight_q   <= inflight_q + 2'(issue) - 2'(push);
      count_q      <= count_q + CW'(push) - CW'(pop);
      if (issue) begin
        cnt_q       <= cnt_q + 5'd1;
        last_addr_q <= cnt_q;
      end
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q   <= rd_q + 1'b1;
        hold_q <= mem_q[rd_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_q] <= wr_pair;
  end

  // With the FIFO empty the last popped pair stays on the outputs.
  assign head              = (count_q != '0) ? mem_q[rd_q] : hold_q;
  assign io.DataOutEnable  = count_q != '0;
  assign io.DataOutAddress = head.addr;
  assign io.DataOutA       = head.a;
  assign io.DataOutB       = head.b;
  assign io.DataOutLast    = io.DataOutEnable & head.last;
endmodule

// File: tb/tb_aq_djpeg_idct_out.sv
// Bench: transpose-buffer model with lane steering, random blocks, and a pixel-level reference queue.
module tb_aq_djpeg_idct_out;
  localparam int SHIFT = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aq_djpeg_idct_out_if bus ();
  aq_djpeg_idct_out #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .io(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Transpose-buffer model: 16 block banks, registered read, lanes steered by live address bit 4.
  logic signed [15:0] memA [16][32];
  logic signed [15:0] memB [16][32];
  int         avail  = 0;
  int         rdb    = 0;
  int         rdblk  = 0;
  logic [4:0] rdaddr = '0;
  int         cyc    = 0;

  assign bus.DataInEnable = avail > (rdb + ((bus.DataInRead && bus.DataInAddress == 5'd31) ? 1 : 0));
  assign bus.DataInA = (bus.DataInAddress[4] == rdaddr[4]) ? memA[rdblk % 16][rdaddr]
                                                           : memB[rdblk % 16][rdaddr];
  assign bus.DataInB = (bus.DataInAddress[4] == rdaddr[4]) ? memB[rdblk % 16][rdaddr]
                                                           : memA[rdblk % 16][rdaddr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || bus.DataInit) begin
      rdb <= 0;
    end else if (bus.DataInRead) begin
      rdaddr <= bus.DataInAddress;
      rdblk  <= rdb;
      if (bus.DataInAddress == 5'd31) rdb <= rdb + 1;
    end
  end

  int rdy_mode = 0;
  initial bus.DataOutReady = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.DataOutReady = (rdy_mode == 0) || (cyc % 3 == 0) ||
                       (rdy_mode == 2 && $urandom_range(0, 1) == 1);
  end

  // Reference: floor((x + round) / 2^SHIFT) + 128, clamped.
  function automatic int px(input int x);
    int d, v, y;
    d = 1 << SHIFT;
    v = x + d / 2;
    y = (v >= 0) ? v / d : -((-v + d - 1) / d);
    y = y + 128;
    return (y < 0) ? 0 : ((y > 255) ? 255 : y);
  endfunction

  typedef struct { int addr; int a; int b; } exp_t;
  exp_t q[$];
  int vals [6] = '{4, -5, -1024, 1016, 2000, -2000};
  int pix  [6] = '{129, 127, 0, 255, 255, 0};

  task automatic put_block(input int mode);
    int k, a, b;
    exp_t e;
    k = avail % 16;
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0:       begin a = 0; b = 0; end
        1:       begin a = vals[i % 6]; b = vals[(i + 3) % 6]; end
        2:       begin a = int'($urandom_range(0, 2047)) - 1024; b = int'($urandom_range(0, 2047)) - 1024; end
        default: begin a = int'($urandom_range(0, 65535)) - 32768; b = int'($urandom_range(0, 65535)) - 32768; end
      endcase
      memA[k][i] = 16'(a);
      memB[k][i] = 16'(b);
      e.addr = i;
      e.a = (mode == 1) ? pix[i % 6] : px(a);
      e.b = (mode == 1) ? pix[(i + 3) % 6] : px(b);
      q.push_back(e);
    end
    avail++;
  endtask

  // Monitor: pops against the reference, credit bound, block-boundary strobes.
  int   outst   = 0;
  int   n31     = 0;
  bit   chk_b2b = 0;
  logic prev31  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst || bus.DataInit) begin
      q.delete();
      outst  = 0;
      prev31 = 1'b0;
    end else begin
      if (bus.DataInRead) outst++;
      if (bus.DataOutEnable && bus.DataOutReady) begin
        outst--;
        if (q.size() == 0) begin
          check("unexpected_pair", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_addr", int'(bus.DataOutAddress), e.addr);
          check("out_pixA", int'(bus.DataOutA), e.a);
          check("out_pixB", int'(bus.DataOutB), e.b);
          check("out_last", int'(bus.DataOutLast), int'(e.addr == 31));
        end
      end
      if (rdy_mode != 0) check("credit_bound", int'(outst <= DEPTH), 1);
      if (chk_b2b && prev31 && n31 == 1)
        check("b2b_no_bubble", int'(bus.DataInRead && bus.DataInAddress == 5'd0), 1);
      prev31 = bus.DataInRead && bus.DataInAddress == 5'd31;
      if (prev31) n31++;
    end
  end

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = (q.size() == 0) && (avail == rdb) && !bus.DataOutEnable && !bus.DataInRead;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rd"},    int'(bus.DataInRead), 0);
    check({pfx, "_raddr"}, int'(bus.DataInAddress), 0);
    check({pfx, "_oen"},   int'(bus.DataOutEnable), 0);
    check({pfx, "_oaddr"}, int'(bus.DataOutAddress), 0);
    check({pfx, "_oa"},    int'(bus.DataOutA), 0);
    check({pfx, "_ob"},    int'(bus.DataOutB), 0);
    check({pfx, "_olast"}, int'(bus.DataOutLast), 0);
  endtask

  task automatic wait_addr10(output bit found);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = bus.DataInRead && bus.DataInAddress == 5'd10;
    end
    if (!found) check("addr10_timeout", 0, 1);
  endtask

  initial begin
    int  k;
    bit  seen, found;
    bus.DataInit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);

    // Zero block: latency from DataInEnable to first DataOutEnable.
    #1; put_block(0); k = cyc; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.DataOutEnable;
    end
    check("first_out_latency", seen ? cyc - k : -1, 3);
    wait_drain();

    @(posedge clk); #1; put_block(1); wait_drain();
    @(posedge clk); #1; put_block(2); wait_drain();

    rdy_mode = 1;
    @(posedge clk); #1; put_block(2); put_block(3); wait_drain();
    rdy_mode = 0;

    n31 = 0; chk_b2b = 1;
    @(posedge clk); #1; put_block(2); put_block(2); wait_drain();
    check("two_31_strobes", n31, 2);
    chk_b2b = 0;

    rdy_mode = 2;
    @(posedge clk); #1; put_block(3); put_block(2); put_block(1); wait_drain();
    rdy_mode = 0;

    // DataInit mid-block, then recovery.
    @(posedge clk); #1; put_block(2);
    wait_addr10(found);
    @(posedge clk); #1; bus.DataInit = 1'b1; avail = 0;
    @(posedge clk); #1; bus.DataInit = 1'b0;
    @(negedge clk);
    check("init_oen", int'(bus.DataOutEnable), 0);
    check("init_rd",  int'(bus.DataInRead), 0);
    @(posedge clk); #1; put_block(2); wait_drain();

    // rst mid-block, then recovery.
    @(posedge clk); #1; put_block(3);
    wait_addr10(found);
    @(posedge clk); #1; rst = 1'b1; avail = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; put_block(3); wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
